// File: rtl/locked_cell_board.sv
// locked_cell_board
//
// Playfield store and move arbiter for the falling piece. Holds a 3-bit
// colour for every locked cell (0 = empty) and answers each movement request
// from the piece store with commit, decline or steal. A steal locks the last
// committed piece into the board, clears full rows and hands the piece back
// for respawn. A registered read port serves the display scanner.
//
// Ports
//   clk                 system clock
//   reset               asynchronous, active-low
//   movement_request    level: pending coordinates are valid
//   movement_intent     0 = natural fall, 1 = player move/rotate
//   P1..P4blk_v/_h      pending cell columns / rows
//   volatile_blk_color  colour of the falling piece
//   movement_commit     one-cycle pulse: move accepted
//   movement_declined   level: move rejected
//   movement_steal      level: piece locked, respawn on falling edge
//   rd_row, rd_col      display read address
//   rd_color            registered board colour at the read address
//   lines_cleared       running cleared-row count (wraps)
//   game_over           one-cycle pulse when the board is wiped
//   fsm_state           current arbiter state, for observation
//
// Handshake: the piece store raises movement_request and holds it until it
// sees commit, declined or steal. commit is a single-cycle pulse; declined
// and steal are levels that fall one cycle after request is sampled low.
// After a commit the arbiter waits for request to go low before it will
// evaluate again, so a stale request never triggers a second evaluation.

module locked_cell_board #(
    parameter int ROWS = 20,
    parameter int COLS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       movement_request,
    input  logic       movement_intent,
    input  logic [4:0] P1blk_v,
    input  logic [4:0] P2blk_v,
    input  logic [4:0] P3blk_v,
    input  logic [4:0] P4blk_v,
    input  logic [4:0] P1blk_h,
    input  logic [4:0] P2blk_h,
    input  logic [4:0] P3blk_h,
    input  logic [4:0] P4blk_h,
    input  logic [2:0] volatile_blk_color,
    output logic       movement_commit,
    output logic       movement_declined,
    output logic       movement_steal,
    input  logic [4:0] rd_row,
    input  logic [4:0] rd_col,
    output logic [2:0] rd_color,
    output logic [7:0] lines_cleared,
    output logic       game_over,
    output logic [3:0] fsm_state
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_SETTLE  = 4'd1,
        S_EVAL    = 4'd2,
        S_COMMIT  = 4'd3,
        S_DECLINE = 4'd4,
        S_LOCK    = 4'd5,
        S_CLEAR   = 4'd6,
        S_WIPE    = 4'd7,
        S_RELEASE = 4'd8,
        S_WAITLOW = 4'd9
    } state_t;

    localparam logic [4:0] ROWS_L   = 5'(ROWS);
    localparam logic [4:0] COLS_L   = 5'(COLS);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    state_t     state, state_nxt;
    logic [2:0] board [ROWS][COLS];
    logic [4:0] pend_h [4];
    logic [4:0] pend_v [4];
    logic [4:0] snap_h [4];
    logic [4:0] snap_v [4];
    logic [2:0] snap_color;
    logic       spawn_fresh;
    logic [4:0] scan_row;
    logic       collide;
    logic       row_full;
    logic [2:0] rd_value;

    assign pend_h[0] = P1blk_h;
    assign pend_h[1] = P2blk_h;
    assign pend_h[2] = P3blk_h;
    assign pend_h[3] = P4blk_h;
    assign pend_v[0] = P1blk_v;
    assign pend_v[1] = P2blk_v;
    assign pend_v[2] = P3blk_v;
    assign pend_v[3] = P4blk_v;

    // A pending cell collides when it is off the board (a negative step wraps
    // to a large unsigned value, so one compare covers both edges) or when it
    // lands on a locked cell.
    always_comb begin
        collide = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (pend_h[i] >= ROWS_L || pend_v[i] >= COLS_L) collide = 1'b1;
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (pend_h[i] == 5'(r) && pend_v[i] == 5'(c) && board[r][c] != 3'd0)
                        collide = 1'b1;
                end
            end
        end
    end

    always_comb begin
        row_full = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            if (scan_row == 5'(r)) begin
                row_full = 1'b1;
                for (int c = 0; c < COLS; c++) begin
                    if (board[r][c] == 3'd0) row_full = 1'b0;
                end
            end
        end
    end

    // Out-of-range addresses match no cell and read back as empty.
    always_comb begin
        rd_value = 3'd0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (rd_row == 5'(r) && rd_col == 5'(c)) rd_value = board[r][c];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (movement_request) state_nxt = S_SETTLE;
            S_SETTLE:  state_nxt = S_EVAL;
            S_EVAL: begin
                if (!collide)             state_nxt = S_COMMIT;
                else if (movement_intent) state_nxt = S_DECLINE;
                else if (!spawn_fresh)    state_nxt = S_LOCK;
                else                      state_nxt = S_WIPE;
            end
            S_COMMIT:  state_nxt = S_WAITLOW;
            S_DECLINE: if (!movement_request) state_nxt = S_IDLE;
            S_LOCK:    state_nxt = S_CLEAR;
            // A full row is rescanned after the shift; only a non-full row
            // moves the scan upward, and leaving row 0 ends the pass.
            S_CLEAR:   if (!row_full && scan_row == 5'd0) state_nxt = S_RELEASE;
            S_WIPE:    state_nxt = S_RELEASE;
            S_RELEASE: if (!movement_request) state_nxt = S_IDLE;
            S_WAITLOW: if (!movement_request) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    assign movement_commit   = (state == S_COMMIT);
    assign movement_declined = (state == S_DECLINE);
    assign movement_steal    = (state == S_LOCK) || (state == S_CLEAR) ||
                               (state == S_WIPE) || (state == S_RELEASE);
    assign game_over         = (state == S_WIPE);
    assign fsm_state         = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    board[r][c] <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                snap_h[i] <= 5'd0;
                snap_v[i] <= 5'd0;
            end
            snap_color    <= 3'd0;
            spawn_fresh   <= 1'b1;
            scan_row      <= 5'd0;
            lines_cleared <= 8'd0;
            rd_color      <= 3'd0;
        end else begin
            rd_color <= rd_value;
            case (state)
                S_EVAL: begin
                    if (!collide) begin
                        for (int i = 0; i < 4; i++) begin
                            snap_h[i] <= pend_h[i];
                            snap_v[i] <= pend_v[i];
                        end
                        snap_color  <= volatile_blk_color;
                        spawn_fresh <= 1'b0;
                    end
                end
                S_LOCK: begin
                    for (int r = 0; r < ROWS; r++)
                        for (int c = 0; c < COLS; c++)
                            for (int i = 0; i < 4; i++)
                                if (snap_h[i] == 5'(r) && snap_v[i] == 5'(c))
                                    board[r][c] <= snap_color;
                    scan_row <= LAST_ROW;
                end
                S_CLEAR: begin
                    if (row_full) begin
                        for (int c = 0; c < COLS; c++) board[0][c] <= 3'd0;
                        for (int r = 1; r < ROWS; r++)
                            if (5'(r) <= scan_row)
                                for (int c = 0; c < COLS; c++)
                                    board[r][c] <= board[r-1][c];
                        lines_cleared <= lines_cleared + 8'd1;
                    end else if (scan_row != 5'd0) begin
                        scan_row <= scan_row - 5'd1;
                    end
                end
                S_WIPE: begin
                    for (int r = 0; r < ROWS; r++)
                        for (int c = 0; c < COLS; c++)
                            board[r][c] <= 3'd0;
                    lines_cleared <= 8'd0;
                end
                S_RELEASE: begin
                    if (!movement_request) spawn_fresh <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_locked_cell_board.sv
module tb_locked_cell_board;
  localparam int ROWS = 20;
  localparam int COLS = 10;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       movement_request = 1'b0;
  logic       req_intent = 1'b0;
  logic [4:0] req_h [4];
  logic [4:0] req_v [4];
  logic [2:0] req_color = 3'd0;
  logic       movement_commit, movement_declined, movement_steal, game_over;
  logic [4:0] rd_row = 5'd0, rd_col = 5'd0;
  logic [2:0] rd_color;
  logic [7:0] lines_cleared;
  logic [3:0] fsm_state;

  locked_cell_board #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .reset(reset),
    .movement_request(movement_request), .movement_intent(req_intent),
    .P1blk_v(req_v[0]), .P2blk_v(req_v[1]), .P3blk_v(req_v[2]), .P4blk_v(req_v[3]),
    .P1blk_h(req_h[0]), .P2blk_h(req_h[1]), .P3blk_h(req_h[2]), .P4blk_h(req_h[3]),
    .volatile_blk_color(req_color),
    .movement_commit(movement_commit), .movement_declined(movement_declined),
    .movement_steal(movement_steal),
    .rd_row(rd_row), .rd_col(rd_col), .rd_color(rd_color),
    .lines_cleared(lines_cleared), .game_over(game_over), .fsm_state(fsm_state)
  );

  int n_checks = 0;
  int n_pass = 0;

  // reference model: board contents, lines, spawn flag, committed snapshot
  int model_b [ROWS][COLS];
  int m_lines;
  bit m_spawn;
  int snap_h [4];
  int snap_v [4];
  int snap_c;

  // observations from the last request handshake
  int obs_code;      // 0 commit, 1 declined, 2 steal, 3 none/ambiguous
  bit obs_quiet;
  int obs_commit_w, obs_decl_w, obs_steal_w, obs_go;
  bit obs_timeout;
  logic [2:0] dut_b [ROWS][COLS];

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) model_b[r][c] = 0;
    m_lines = 0;
    m_spawn = 1'b1;
    for (int i = 0; i < 4; i++) begin snap_h[i] = 0; snap_v[i] = 0; end
    snap_c = 0;
  endtask

  // Remove every full row and let the rows above fall; returns rows removed.
  task automatic model_clear_rows(output int k);
    int nb [ROWS][COLS];
    int dst;
    bit full;
    k = 0;
    dst = ROWS - 1;
    for (int r = ROWS - 1; r >= 0; r--) begin
      full = 1'b1;
      for (int c = 0; c < COLS; c++) if (model_b[r][c] == 0) full = 1'b0;
      if (full) k++;
      else begin
        for (int c = 0; c < COLS; c++) nb[dst][c] = model_b[r][c];
        dst--;
      end
    end
    for (int r = dst; r >= 0; r--) for (int c = 0; c < COLS; c++) nb[r][c] = 0;
    model_b = nb;
  endtask

  // code: 0 commit, 1 decline, 2 lock, 3 wipe; k = rows cleared
  task automatic model_request(output int code, output int k);
    bit hit;
    int hh, vv;
    hit = 1'b0;
    k = 0;
    for (int i = 0; i < 4; i++) begin
      hh = int'(req_h[i]);
      vv = int'(req_v[i]);
      if (hh >= ROWS || vv >= COLS) hit = 1'b1;
      else if (model_b[hh][vv] != 0) hit = 1'b1;
    end
    if (!hit) begin
      code = 0;
      for (int i = 0; i < 4; i++) begin snap_h[i] = int'(req_h[i]); snap_v[i] = int'(req_v[i]); end
      snap_c = int'(req_color);
      m_spawn = 1'b0;
    end else if (req_intent) begin
      code = 1;
    end else if (!m_spawn) begin
      code = 2;
      for (int i = 0; i < 4; i++) model_b[snap_h[i]][snap_v[i]] = snap_c;
      model_clear_rows(k);
      m_lines = (m_lines + k) % 256;
      m_spawn = 1'b1;
    end else begin
      code = 3;
      for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) model_b[r][c] = 0;
      m_lines = 0;
      m_spawn = 1'b1;
    end
  endtask

  // driver tasks
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    movement_request = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic set_piece(input int h0, input int h1, input int h2, input int h3,
                           input int v0, input int v1, input int v2, input int v3,
                           input logic intent, input logic [2:0] color);
    req_h[0] = 5'(h0); req_h[1] = 5'(h1); req_h[2] = 5'(h2); req_h[3] = 5'(h3);
    req_v[0] = 5'(v0); req_v[1] = 5'(v1); req_v[2] = 5'(v2); req_v[3] = 5'(v3);
    req_intent = intent;
    req_color = color;
  endtask

  // Raise the request, observe the response and complete the handshake.
  task automatic run_request(input int hold_extra);
    obs_quiet = 1'b1; obs_code = 3; obs_commit_w = 0; obs_decl_w = 0;
    obs_steal_w = 0; obs_go = 0; obs_timeout = 1'b0;
    @(negedge clk);
    movement_request = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      if (movement_commit || movement_declined || movement_steal || game_over) obs_quiet = 1'b0;
    end
    @(posedge clk); #1;
    if (movement_commit && !movement_declined && !movement_steal) obs_code = 0;
    else if (movement_declined && !movement_commit && !movement_steal) obs_code = 1;
    else if (movement_steal && !movement_commit && !movement_declined) obs_code = 2;
    case (obs_code)
      0: begin
        obs_commit_w = 1;
        for (int i = 0; i < 1 + hold_extra; i++) begin
          @(posedge clk); #1;
          if (movement_commit) obs_commit_w++;
        end
        @(negedge clk);
        movement_request = 1'b0;
        @(posedge clk); #1;
        if (movement_commit) obs_commit_w++;
      end
      1: begin
        obs_decl_w = 1;
        @(posedge clk); #1;
        if (movement_declined) obs_decl_w++;
        @(negedge clk);
        movement_request = 1'b0;
        obs_timeout = 1'b1;
        for (int i = 0; i < 10; i++) begin
          @(posedge clk); #1;
          if (movement_declined) obs_decl_w++;
          else begin obs_timeout = 1'b0; break; end
        end
      end
      2: begin
        obs_steal_w = 1;
        obs_go = int'(game_over);
        @(negedge clk);
        movement_request = 1'b0;
        obs_timeout = 1'b1;
        for (int i = 0; i < 300; i++) begin
          @(posedge clk); #1;
          if (movement_steal) begin
            obs_steal_w++;
            obs_go += int'(game_over);
          end else begin obs_timeout = 1'b0; break; end
        end
      end
      default: begin
        @(negedge clk);
        movement_request = 1'b0;
        repeat (40) @(posedge clk);
      end
    endcase
  endtask

  task automatic read_board();
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        @(negedge clk);
        rd_row = 5'(r);
        rd_col = 5'(c);
        @(posedge clk); #1;
        dut_b[r][c] = rd_color;
      end
    end
  endtask

  // tests
  task automatic test_reset();
    reset = 1'b0;
    #3;
    n_checks++;
    if ({movement_commit, movement_declined, movement_steal, game_over} !== 4'b0000)
      $display("FAIL reset_flags: got %b want 0000",
               {movement_commit, movement_declined, movement_steal, game_over});
    else n_pass++;
    apply_reset();
    #1;
    n_checks++;
    if (lines_cleared !== 8'd0) $display("FAIL reset_lines: got %0d want 0", lines_cleared);
    else n_pass++;
    n_checks++;
    if (rd_color !== 3'd0) $display("FAIL reset_rd_color: got %0d want 0", rd_color);
    else n_pass++;
    read_board();
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) begin
      n_checks++;
      if (dut_b[r][c] !== 3'(model_b[r][c]))
        $display("FAIL reset_board r%0d c%0d: got %0d want %0d", r, c, dut_b[r][c], model_b[r][c]);
      else n_pass++;
    end
  endtask

  task automatic test_commit();
    int code, k;
    set_piece(5, 6, 5, 6, 0, 0, 1, 1, 1'b1, 3'd3);
    model_request(code, k);
    run_request(2);
    n_checks++;
    if (obs_quiet !== 1'b1) $display("FAIL commit_early: response before t+3 (got %0d want 1)", obs_quiet);
    else n_pass++;
    n_checks++;
    if (obs_code !== code) $display("FAIL commit_outcome: got %0d want %0d", obs_code, code);
    else n_pass++;
    n_checks++;
    if (obs_commit_w !== 1) $display("FAIL commit_width: got %0d want 1", obs_commit_w);
    else n_pass++;
    read_board();
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) begin
      n_checks++;
      if (dut_b[r][c] !== 3'(model_b[r][c]))
        $display("FAIL commit_board r%0d c%0d: got %0d want %0d", r, c, dut_b[r][c], model_b[r][c]);
      else n_pass++;
    end
  endtask

  task automatic test_decline();
    int code, k;
    set_piece(5, 5, 6, 6, 31, 0, 0, 1, 1'b1, 3'd2);
    model_request(code, k);
    run_request(0);
    n_checks++;
    if (obs_code !== code) $display("FAIL decline_outcome: got %0d want %0d", obs_code, code);
    else n_pass++;
    n_checks++;
    if (obs_decl_w !== 2 || obs_timeout) $display("FAIL decline_width: got %0d want 2", obs_decl_w);
    else n_pass++;
    n_checks++;
    if (lines_cleared !== 8'(m_lines)) $display("FAIL decline_lines: got %0d want %0d", lines_cleared, m_lines);
    else n_pass++;
  endtask

  task automatic test_lock();
    int code, k;
    logic [4:0] oor_r [3];
    logic [4:0] oor_c [3];
    set_piece(18, 18, 19, 19, 3, 4, 3, 4, 1'b1, 3'd5);
    model_request(code, k);
    run_request(0);
    n_checks++;
    if (obs_code !== code) $display("FAIL lock_setup_commit: got %0d want %0d", obs_code, code);
    else n_pass++;
    set_piece(19, 19, 20, 20, 3, 4, 3, 4, 1'b0, 3'd5);
    model_request(code, k);
    run_request(0);
    n_checks++;
    if (obs_code !== 2) $display("FAIL lock_outcome: got %0d want 2 (model %0d)", obs_code, code);
    else n_pass++;
    n_checks++;
    if (obs_steal_w !== 22 + k || obs_timeout) $display("FAIL lock_steal_width: got %0d want %0d", obs_steal_w, 22 + k);
    else n_pass++;
    n_checks++;
    if (obs_go !== 0) $display("FAIL lock_game_over: got %0d want 0", obs_go);
    else n_pass++;
    read_board();
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) begin
      n_checks++;
      if (dut_b[r][c] !== 3'(model_b[r][c]))
        $display("FAIL lock_board r%0d c%0d: got %0d want %0d", r, c, dut_b[r][c], model_b[r][c]);
      else n_pass++;
    end
    oor_r[0] = 5'd20; oor_c[0] = 5'd3;
    oor_r[1] = 5'd19; oor_c[1] = 5'd10;
    oor_r[2] = 5'd31; oor_c[2] = 5'd31;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rd_row = oor_r[i];
      rd_col = oor_c[i];
      @(posedge clk); #1;
      n_checks++;
      if (rd_color !== 3'd0) $display("FAIL rd_out_of_range %0d,%0d: got %0d want 0", oor_r[i], oor_c[i], rd_color);
      else n_pass++;
    end
  endtask

  task automatic test_line_clear();
    int code, k;
    int base_v [3];
    logic [2:0] col [3];
    apply_reset();
    base_v[0] = 0; base_v[1] = 6; col[0] = 3'd2; col[1] = 3'd3;
    for (int p = 0; p < 2; p++) begin
      set_piece(19, 19, 19, 19, base_v[p], base_v[p] + 1, base_v[p] + 2, base_v[p] + 3, 1'b1, col[p]);
      model_request(code, k);
      run_request(0);
      set_piece(20, 20, 20, 20, base_v[p], base_v[p] + 1, base_v[p] + 2, base_v[p] + 3, 1'b0, col[p]);
      model_request(code, k);
      run_request(0);
      n_checks++;
      if (obs_code !== 2) $display("FAIL fill_lock%0d: got %0d want 2", p, obs_code);
      else n_pass++;
    end
    set_piece(18, 18, 19, 19, 4, 5, 4, 5, 1'b1, 3'd6);
    model_request(code, k);
    run_request(0);
    set_piece(19, 19, 20, 20, 4, 5, 4, 5, 1'b0, 3'd6);
    model_request(code, k);
    run_request(0);
    n_checks++;
    if (obs_steal_w !== 22 + k || obs_timeout) $display("FAIL clear_steal_width: got %0d want %0d", obs_steal_w, 22 + k);
    else n_pass++;
    n_checks++;
    if (lines_cleared !== 8'(m_lines)) $display("FAIL clear_lines: got %0d want %0d", lines_cleared, m_lines);
    else n_pass++;
    read_board();
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) begin
      n_checks++;
      if (dut_b[r][c] !== 3'(model_b[r][c]))
        $display("FAIL clear_board r%0d c%0d: got %0d want %0d", r, c, dut_b[r][c], model_b[r][c]);
      else n_pass++;
    end
  endtask

  task automatic test_wipe();
    int code, k;
    set_piece(20, 20, 20, 20, 0, 1, 2, 3, 1'b0, 3'd1);
    model_request(code, k);
    run_request(0);
    n_checks++;
    if (obs_code !== 2) $display("FAIL wipe_outcome: got %0d want 2 (model %0d)", obs_code, code);
    else n_pass++;
    n_checks++;
    if (obs_steal_w !== 2 || obs_timeout) $display("FAIL wipe_steal_width: got %0d want 2", obs_steal_w);
    else n_pass++;
    n_checks++;
    if (obs_go !== 1) $display("FAIL wipe_game_over: got %0d want 1", obs_go);
    else n_pass++;
    n_checks++;
    if (lines_cleared !== 8'(m_lines)) $display("FAIL wipe_lines: got %0d want %0d", lines_cleared, m_lines);
    else n_pass++;
    read_board();
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) begin
      n_checks++;
      if (dut_b[r][c] !== 3'(model_b[r][c]))
        $display("FAIL wipe_board r%0d c%0d: got %0d want %0d", r, c, dut_b[r][c], model_b[r][c]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_clear();
    int code, k;
    bit seen;
    set_piece(10, 10, 11, 11, 2, 3, 2, 3, 1'b1, 3'd4);
    model_request(code, k);
    run_request(0);
    @(negedge clk);
    rd_row = 5'd10;
    rd_col = 5'd2;
    set_piece(11, 11, 12, 12, 31, 0, 31, 0, 1'b0, 3'd4);
    movement_request = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (movement_steal) begin seen = 1'b1; break; end
    end
    n_checks++;
    if (!seen) $display("FAIL midclear_steal: got 0 want 1");
    else n_pass++;
    repeat (5) @(posedge clk);
    #2;
    n_checks++;
    if (rd_color !== 3'd4) $display("FAIL midclear_locked_cell: got %0d want 4", rd_color);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({movement_commit, movement_declined, movement_steal, game_over} !== 4'b0000 ||
        rd_color !== 3'd0 || lines_cleared !== 8'd0)
      $display("FAIL midclear_async_reset: got flags %b rd %0d lines %0d want all 0",
               {movement_commit, movement_declined, movement_steal, game_over}, rd_color, lines_cleared);
    else n_pass++;
    movement_request = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    read_board();
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) begin
      n_checks++;
      if (dut_b[r][c] !== 3'(model_b[r][c]))
        $display("FAIL midclear_board r%0d c%0d: got %0d want %0d", r, c, dut_b[r][c], model_b[r][c]);
      else n_pass++;
    end
    set_piece(10, 10, 11, 11, 2, 3, 2, 3, 1'b1, 3'd7);
    model_request(code, k);
    run_request(0);
    n_checks++;
    if (obs_code !== code || obs_commit_w !== 1)
      $display("FAIL midclear_next_request: got code %0d width %0d want %0d width 1", obs_code, obs_commit_w, code);
    else n_pass++;
  endtask

  task automatic test_random();
    int code, k, h0, v0, exp_obs, exp_w, got_w;
    for (int it = 0; it < 40; it++) begin
      h0 = $urandom_range(15, 19);
      v0 = $urandom_range(0, 10);
      if (v0 == 10) v0 = 31;
      set_piece(h0, h0, h0 + 1, h0 + 1, v0, (v0 + 1) % 32, v0, (v0 + 1) % 32,
                1'($urandom_range(0, 2) == 0), 3'($urandom_range(1, 7)));
      model_request(code, k);
      run_request($urandom_range(0, 3));
      exp_obs = (code == 3) ? 2 : code;
      exp_w = (code == 0) ? 1 : (code == 1) ? 2 : (code == 2) ? 22 + k : 2;
      got_w = (obs_code == 0) ? obs_commit_w : (obs_code == 1) ? obs_decl_w : obs_steal_w;
      n_checks++;
      if (obs_code !== exp_obs || obs_quiet !== 1'b1)
        $display("FAIL rand%0d_outcome: got %0d quiet %0d want %0d quiet 1", it, obs_code, obs_quiet, exp_obs);
      else n_pass++;
      n_checks++;
      if (got_w !== exp_w || obs_timeout) $display("FAIL rand%0d_width: got %0d want %0d", it, got_w, exp_w);
      else n_pass++;
      n_checks++;
      if (obs_go !== int'(code == 3)) $display("FAIL rand%0d_game_over: got %0d want %0d", it, obs_go, int'(code == 3));
      else n_pass++;
      n_checks++;
      if (lines_cleared !== 8'(m_lines)) $display("FAIL rand%0d_lines: got %0d want %0d", it, lines_cleared, m_lines);
      else n_pass++;
      if (code >= 2) begin
        read_board();
        for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) begin
          n_checks++;
          if (dut_b[r][c] !== 3'(model_b[r][c]))
            $display("FAIL rand%0d_board r%0d c%0d: got %0d want %0d", it, r, c, dut_b[r][c], model_b[r][c]);
          else n_pass++;
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin req_h[i] = 5'd0; req_v[i] = 5'd0; end
    model_reset();
    test_reset();
    test_commit();
    test_decline();
    test_lock();
    test_line_clear();
    test_wipe();
    test_reset_mid_clear();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached (passed %0d of %0d)", n_pass, n_checks);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/locked_cell_board.md
# locked_cell_board

Playfield store and move arbiter directly downstream of the falling-piece cell storage. It holds every locked cell's 3-bit colour and answers each movement request from the falling piece with commit, decline or steal. A steal locks the last committed piece into the board, clears full rows and hands the piece back for respawn. A registered read port serves the display scanner.

## Interface
- ROWS, 20, board height; row index = piece `h` coordinate, 0 = top; max 31.
- COLS, 10, board width; column index = piece `v` coordinate; max 31.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low.
- movement_request  in  1  level from the piece store; the four coordinates are pending.
- movement_intent  in  1  0 = natural fall (gametick/drop), 1 = player move or rotate.
- P1blk_v..P4blk_v  in  5 each  pending cell columns.
- P1blk_h..P4blk_h  in  5 each  pending cell rows.
- volatile_blk_color  in  3  colour of the falling piece.
- movement_commit  out  1  one-cycle pulse; move accepted.
- movement_declined  out  1  level; move rejected, piece reverts.
- movement_steal  out  1  level; piece locked, respawn on falling edge.
- rd_row  in  5  display read row.
- rd_col  in  5  display read column.
- rd_color  out  3  board colour at (rd_row, rd_col); 0 = empty.
- lines_cleared  out  8  running cleared-row count, wraps at 255.
- game_over  out  1  one-cycle pulse when the board is wiped.

## Operation
- Storage: ROWS×COLS×3-bit register array. Colour 0 means empty.
- Committed snapshot: on every commit, latch the four coordinate pairs and volatile_blk_color.
- spawn_fresh flag: set at reset and at every steal release; cleared at every commit.
- Collision for a pending cell: h ≥ ROWS, or v ≥ COLS (this covers unsigned wrap from a negative step), or the board cell is non-zero.
- States:
  - IDLE: on movement_request=1 → SETTLE.
  - SETTLE: one cycle for the shaper outputs to settle → EVAL.
  - EVAL: test all four cells.
    - No collision → COMMIT.
    - Collision and intent=1 → DECLINE.
    - Collision, intent=0, spawn_fresh=0 → LOCK.
    - Collision, intent=0, spawn_fresh=1 → WIPE.
  - COMMIT: commit=1 for exactly one cycle → WAITLOW.
  - DECLINE: declined=1, held until movement_request is sampled low → IDLE, declined=0.
  - LOCK: steal=1. Write the snapshot colour into the four snapshot cells in a single cycle → CLEAR with scan row = ROWS-1.
  - CLEAR: steal stays 1.
    - Scan row full (all COLS non-zero): every row r ≤ scan copies row r-1, row 0 becomes empty, lines_cleared++, same row rescanned.
    - Scan row not full: scan row--. Past row 0 → RELEASE.
  - WIPE: steal=1, whole board cleared in one cycle, game_over pulse, lines_cleared=0 → RELEASE.
  - RELEASE: hold steal until request is sampled low, then steal=0, set spawn_fresh → IDLE.
  - WAITLOW: → IDLE once request is sampled low. This stops a stale request from re-triggering an evaluation.
- The read port is independent of the FSM. rd_color is registered. Out-of-range rd_row/rd_col returns 0.

## Timing
- Reset (asynchronous): board empty, FSM=IDLE, spawn_fresh=1, snapshot=0.
- Output reset values: commit=0, declined=0, steal=0, rd_color=0, lines_cleared=0, game_over=0.
- Request sampled high at edge t:
  - SETTLE at t+1, EVAL at t+2.
  - commit/declined/steal rises at t+3.
- commit is exactly one cycle wide. The piece store drops request on seeing it. The FSM reaches IDLE no earlier than t+5.
- declined and steal stay high for at least 2 cycles. Each falls one cycle after request is sampled low.
- Lock-to-release: 1 (LOCK) + ROWS + (rows cleared) CLEAR cycles + RELEASE wait.
- rd_color: 1-cycle latency from rd_row/rd_col.
- A request that arrives while not in IDLE is only evaluated after the FSM returns to IDLE.
- A reset assertion mid-lock or mid-clear aborts it immediately. Partially shifted rows are discarded by the board wipe.

## Test plan
- Empty board, request intent=1, cells (5,0),(6,0),(5,1),(6,1) → commit pulse at t+3, one cycle wide; board unchanged.
- Request intent=1 with one cell at v=31 (wrapped -1) → declined high from t+3 until 1 cycle after request drops; no commit; board unchanged.
- Commit piece at rows 18–19, then intent=0 request at rows 19–20 → steal. rd_color at the four committed cells returns the committed colour. steal falls after request drops.
- Pre-fill row 19 except columns 4–5, lock an O piece covering (4..5, 18..19) → row 19 cleared, former row 18 content moves to row 19, lines_cleared=1.
- After a steal, with no commit since, intent=0 request collides → board all zero, game_over one-cycle pulse, lines_cleared=0, steal handshake completes.
- Assert reset during CLEAR → all outputs 0 asynchronously; board empty; next request evaluated normally.
